// File: rtl/fcl_multi_arbiter.sv
// fcl_multi_arbiter: latches field-config-load commands as pending requests and grants
// one at a time (fixed priority or round-robin), issuing a one-cycle o_go when loading
// is allowed, supervising the loader start with a timeout and enforcing a post-load cooldown.
// Ports: clk/rst_n (async active-low); i_cmd per-slot command pulses; i_fcl_allowed gates
// grants; i_is_loading loader busy flag; o_go start pulse; o_req_valid/o_req_idx granted
// slot; o_pending pending vector; o_busy not idle; o_timeout start-timeout abort pulse.
module fcl_multi_arbiter #(
   parameter int N_CFG         = 4,
   parameter int RR_MODE       = 0,
   parameter int START_TIMEOUT = 16,
   parameter int COOLDOWN      = 2,
   parameter int IDX_W         = $clog2(N_CFG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CFG-1:0] i_cmd,
   input  logic             i_fcl_allowed,
   input  logic             i_is_loading,
   output logic             o_go,
   output logic             o_req_valid,
   output logic [IDX_W-1:0] o_req_idx,
   output logic [N_CFG-1:0] o_pending,
   output logic             o_busy,
   output logic             o_timeout
);

   // One counter serves both the start timeout and the cooldown, so size it for the larger.
   localparam int CNT_MAX = (START_TIMEOUT > COOLDOWN) ? START_TIMEOUT : COOLDOWN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CD_LAST = CNT_W'((COOLDOWN > 0) ? (COOLDOWN - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_START,
      S_LOADING,
      S_COOLDOWN
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [N_CFG-1:0]   pending_q, pending_d;
   logic [IDX_W-1:0]   last_q;
   logic               go_q, valid_q, timeout_q;
   logic [IDX_W-1:0]   idx_q;

   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic [IDX_W-1:0]   cand_idx;
   int                 cand;
   logic               grant_en;
   logic [N_CFG-1:0]   grant_mask;

   // Grant selection looks only at the registered pending vector. In round-robin mode
   // the search starts one past the previous grant and wraps.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < N_CFG; i++) begin
         cand     = (RR_MODE != 0) ? ((int'(last_q) + 1 + i) % N_CFG) : i;
         cand_idx = IDX_W'(cand);
         if (!sel_found && pending_q[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   // An externally raised i_is_loading blocks a grant even when allowed.
   assign grant_en   = (state_q == S_IDLE) && sel_found && i_fcl_allowed && !i_is_loading;
   assign grant_mask = grant_en ? ({{(N_CFG-1){1'b0}}, 1'b1} << sel_idx) : '0;
   // A command for the slot being granted this cycle re-sets its bit for a later reload.
   assign pending_d  = (pending_q & ~grant_mask) | i_cmd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pending_q <= '0;
         last_q    <= IDX_W'(N_CFG - 1);
         go_q      <= 1'b0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         go_q      <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_en) begin
                  state_q <= S_WAIT_START;
                  go_q    <= 1'b1;
                  valid_q <= 1'b1;
                  idx_q   <= sel_idx;
                  last_q  <= sel_idx;
                  cnt_q   <= '0;
               end
            end
            S_WAIT_START: begin
               if (i_is_loading) begin
                  state_q <= S_LOADING;
                  cnt_q   <= '0;
               end else if (cnt_q == TO_LAST) begin
                  // Abort: the request is dropped, not re-queued.
                  state_q   <= S_IDLE;
                  timeout_q <= 1'b1;
                  valid_q   <= 1'b0;
                  idx_q     <= '0;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_LOADING: begin
               if (!i_is_loading) begin
                  valid_q <= 1'b0;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= (COOLDOWN > 0) ? S_COOLDOWN : S_IDLE;
               end
            end
            S_COOLDOWN: begin
               if (cnt_q == CD_LAST) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign o_go        = go_q;
   assign o_req_valid = valid_q;
   assign o_req_idx   = idx_q;
   assign o_pending   = pending_q;
   assign o_busy      = (state_q != S_IDLE);
   assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_fcl_multi_arbiter.sv
// Bench for fcl_multi_arbiter: two instances (fixed priority T=16 C=2, round-robin T=5 C=0)
// driven with directed sequences then random commands and an emulated loader, compared
// every cycle against an event-time model, plus literal expectations for key cycles.
module tb_fcl_multi_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] cmd [2];
   logic         allowed [2];
   logic         loading [2];
   logic         go [2];
   logic         valid [2];
   logic [1:0]   idx [2];
   logic [N-1:0] pend [2];
   logic         busy [2];
   logic         tout [2];

   fcl_multi_arbiter #(.N_CFG(4), .RR_MODE(0), .START_TIMEOUT(16), .COOLDOWN(2)) u_fix (
      .clk(clk), .rst_n(rst_n), .i_cmd(cmd[0]), .i_fcl_allowed(allowed[0]),
      .i_is_loading(loading[0]), .o_go(go[0]), .o_req_valid(valid[0]), .o_req_idx(idx[0]),
      .o_pending(pend[0]), .o_busy(busy[0]), .o_timeout(tout[0]));

   fcl_multi_arbiter #(.N_CFG(4), .RR_MODE(1), .START_TIMEOUT(5), .COOLDOWN(0)) u_rr (
      .clk(clk), .rst_n(rst_n), .i_cmd(cmd[1]), .i_fcl_allowed(allowed[1]),
      .i_is_loading(loading[1]), .o_go(go[1]), .o_req_valid(valid[1]), .o_req_idx(idx[1]),
      .o_pending(pend[1]), .o_busy(busy[1]), .o_timeout(tout[1]));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int T_of  [2] = '{16, 5};
   int C_of  [2] = '{2, 0};
   int RR_of [2] = '{0, 1};

   // Model: phase 0 idle, 1 waiting for loader start, 2 loading, 3 cooldown.
   // Deadlines are kept as absolute cycle numbers.
   int         m_phase [2];
   logic [3:0] m_pend [2];
   int         m_last [2];
   int         m_idx [2];
   logic       m_valid [2];
   logic       m_go [2];
   logic       m_to [2];
   int         m_go_cyc [2];
   int         m_cool_end [2];

   int ld_wait [2];
   int ld_hold [2];

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = 0; m_pend[d] = '0; m_last[d] = N - 1; m_idx[d] = 0;
         m_valid[d] = 1'b0; m_go[d] = 1'b0; m_to[d] = 1'b0;
         m_go_cyc[d] = 0; m_cool_end[d] = 0;
      end
   endtask

   function automatic int pick(input logic [3:0] p, input int rr, input int last);
      if (rr == 0) begin
         for (int i = 0; i < N; i++) if (p[i]) return i;
      end else begin
         for (int s = 1; s <= N; s++) if (p[(last + s) % N]) return (last + s) % N;
      end
      return -1;
   endfunction

   // Advance the model across the coming clock edge using the inputs applied now.
   task automatic model_step(input int d);
      logic [3:0] gmask;
      int k;
      gmask = '0;
      m_go[d] = 1'b0;
      m_to[d] = 1'b0;
      case (m_phase[d])
         0: if (m_pend[d] != 0 && allowed[d] && !loading[d]) begin
               k = pick(m_pend[d], RR_of[d], m_last[d]);
               gmask[k] = 1'b1;
               m_idx[d] = k; m_last[d] = k; m_valid[d] = 1'b1; m_go[d] = 1'b1;
               m_go_cyc[d] = cyc + 1;
               m_phase[d] = 1;
            end
         1: if (loading[d]) m_phase[d] = 2;
            else if (cyc + 1 == m_go_cyc[d] + T_of[d]) begin
               m_to[d] = 1'b1; m_valid[d] = 1'b0; m_idx[d] = 0; m_phase[d] = 0;
            end
         2: if (!loading[d]) begin
               m_valid[d] = 1'b0; m_idx[d] = 0;
               if (C_of[d] > 0) begin
                  m_phase[d] = 3;
                  m_cool_end[d] = cyc + 1 + C_of[d];
               end else m_phase[d] = 0;
            end
         default: if (cyc + 1 == m_cool_end[d]) m_phase[d] = 0;
      endcase
      m_pend[d] = (m_pend[d] & ~gmask) | cmd[d];
   endtask

   // One clock: step model, sample DUTs after the edge, compare every output.
   task automatic cycle();
      for (int d = 0; d < 2; d++) model_step(d);
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         chk("go", d, go[d], m_go[d]);
         chk("req_valid", d, valid[d], m_valid[d]);
         chk("req_idx", d, idx[d], m_idx[d]);
         chk("pending", d, pend[d], m_pend[d]);
         chk("busy", d, busy[d], (m_phase[d] != 0));
         chk("timeout", d, tout[d], m_to[d]);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      for (int d = 0; d < 2; d++) begin
         chk({nm, "_go"}, d, go[d], 0);
         chk({nm, "_valid"}, d, valid[d], 0);
         chk({nm, "_idx"}, d, idx[d], 0);
         chk({nm, "_pend"}, d, pend[d], 0);
         chk({nm, "_busy"}, d, busy[d], 0);
         chk({nm, "_timeout"}, d, tout[d], 0);
      end
   endtask

   initial begin
      logic got;
      int w;
      int rr_exp [5];
      rr_exp = '{0, 1, 2, 3, 0};
      for (int d = 0; d < 2; d++) begin
         cmd[d] = '0; allowed[d] = 1'b1; loading[d] = 1'b0;
         ld_wait[d] = -1; ld_hold[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      model_reset();

      // Single command, fixed priority.
      cmd[0] = 4'b0100; cycle(); cmd[0] = '0;
      chk("lit_pend_t1", 0, pend[0], 4'b0100);
      cycle();
      chk("lit_go_t2", 0, go[0], 1); chk("lit_idx_t2", 0, idx[0], 2);
      chk("lit_pend_t2", 0, pend[0], 0); chk("lit_busy_t2", 0, busy[0], 1);
      loading[0] = 1'b1; cycle();
      chk("lit_go_t3", 0, go[0], 0); chk("lit_idx_t3", 0, idx[0], 2);
      repeat (3) begin cycle(); chk("lit_idx_hold", 0, idx[0], 2); end
      loading[0] = 1'b0; cycle();
      chk("lit_valid_cool", 0, valid[0], 0); chk("lit_busy_cool", 0, busy[0], 1);
      repeat (3) cycle();

      // Simultaneous commands: grants 1 then 3.
      cmd[0] = 4'b1010; cycle(); cmd[0] = '0;
      chk("lit_pend_1010", 0, pend[0], 4'b1010);
      cycle();
      chk("lit_go_a", 0, go[0], 1); chk("lit_idx_a", 0, idx[0], 1);
      chk("lit_pend_1000", 0, pend[0], 4'b1000);
      loading[0] = 1'b1; cycle(); cycle();
      loading[0] = 1'b0; cycle(); cycle(); cycle();
      chk("lit_no_go_cool", 0, go[0], 0);
      cycle();
      chk("lit_go_b", 0, go[0], 1); chk("lit_idx_b", 0, idx[0], 3);
      chk("lit_pend_0000", 0, pend[0], 0);
      loading[0] = 1'b1; cycle(); loading[0] = 1'b0;
      repeat (4) cycle();

      // Round-robin fairness on the second instance.
      for (int n = 0; n < 5; n++) begin
         cmd[1] = 4'b1111; cycle(); cmd[1] = '0;
         got = go[1]; w = 1;
         while (!got && w < 12) begin cycle(); w++; got = go[1]; end
         chk("rr_go_seen", 1, got, 1);
         chk("rr_order", 1, idx[1], rr_exp[n]);
         loading[1] = 1'b1; cycle(); loading[1] = 1'b0; cycle();
      end

      // Allowed gating.
      allowed[0] = 1'b0; cmd[0] = 4'b0001; cycle(); cmd[0] = '0;
      repeat (10) begin cycle(); chk("lit_gated_go", 0, go[0], 0); end
      allowed[0] = 1'b1; cycle();
      chk("lit_go_allowed", 0, go[0], 1); chk("lit_idx_allowed", 0, idx[0], 0);

      // Start timeout, loader never starts.
      for (int k = 1; k < 16; k++) begin cycle(); chk("lit_no_timeout", 0, tout[0], 0); end
      cycle();
      chk("lit_timeout_pulse", 0, tout[0], 1);
      cycle();
      chk("lit_timeout_end", 0, tout[0], 0); chk("lit_valid_after_to", 0, valid[0], 0);
      chk("lit_idle_after_to", 0, busy[0], 0);

      // Same-slot recommand in the grant cycle, then reset during the load.
      cmd[0] = 4'b0010; cycle();
      chk("lit_pend_0010", 0, pend[0], 4'b0010);
      cycle(); cmd[0] = '0;
      chk("lit_go_recmd", 0, go[0], 1); chk("lit_idx_recmd", 0, idx[0], 1);
      chk("lit_pend_kept", 0, pend[0], 4'b0010);
      loading[0] = 1'b1; cycle(); cycle();
      chk("lit_loading_valid", 0, valid[0], 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin cmd[d] = '0; loading[d] = 1'b0; allowed[d] = 1'b1; end
      rst_n = 1'b1;
      model_reset();

      // Random traffic with an emulated loader.
      for (int it = 0; it < 3000; it++) begin
         for (int d = 0; d < 2; d++) begin
            if (go[d]) ld_wait[d] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T_of[d] + 1));
            if (ld_hold[d] > 0) begin
               loading[d] = 1'b1; ld_hold[d]--;
            end else if (ld_wait[d] == 0) begin
               loading[d] = 1'b1; ld_hold[d] = int'($urandom_range(0, 5)); ld_wait[d] = -1;
            end else begin
               if (ld_wait[d] > 0) ld_wait[d]--;
               loading[d] = ($urandom_range(0, 39) == 0);
            end
            cmd[d] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            allowed[d] = ($urandom_range(0, 5) != 0);
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fcl_multi_arbiter.md
# fcl_multi_arbiter

Parametrised field-config-load (FCL) request arbiter for the Game of Life core, sitting between the debounced command inputs and the field config loader. It accepts load commands for `N_CFG` stored configurations and latches them as pending requests. It grants one request at a time, using fixed-priority or round-robin selection, and issues a single-cycle `o_go` only when loading is allowed. The granted index is held stable for the whole load, and the block supervises load start with a timeout and enforces a post-load cooldown.

## Interface
- `N_CFG`, default 4: number of configuration slots. Must be ≥ 2.
- `RR_MODE`, default 0: 0 = fixed priority, lowest index wins; 1 = round-robin.
- `START_TIMEOUT`, default 16: cycles to wait in WAIT_START for `i_is_loading` to rise. Must be ≥ 1.
- `COOLDOWN`, default 2: idle cycles after a load ends before the next grant. 0 = none.
- `IDX_W`, default `$clog2(N_CFG)`: width of the index. Derived; do not override.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_cmd`  in  `N_CFG`  one-cycle command pulses; bit k requests config k. Several bits may be high at once.
- `i_fcl_allowed`  in  1  loading permitted; gates grant only.
- `i_is_loading`  in  1  loader busy flag.
- `o_go`  out  1  single-cycle start pulse to the loader.
- `o_req_valid`  out  1  `o_req_idx` is meaningful.
- `o_req_idx`  out  `IDX_W`  granted config index.
- `o_pending`  out  `N_CFG`  registered pending-request vector.
- `o_busy`  out  1  state ≠ IDLE.
- `o_timeout`  out  1  single-cycle pulse when a grant is aborted in WAIT_START.

## Operation
- Pending update every cycle: `pending <= (pending & ~grant_mask) | i_cmd`.
  - A repeated command for an already-pending slot coalesces.
  - A command arriving in the same cycle as that slot's grant leaves the bit set, so the slot reloads later.
- Grant selection uses the registered `pending` only.
  - `RR_MODE=0`: lowest set index.
  - `RR_MODE=1`: first set index searching from `last_grant+1`, wrapping modulo `N_CFG`. `last_grant` updates on each grant.
- FSM states: IDLE, WAIT_START, LOADING, COOLDOWN.
- IDLE:
  - If `pending≠0` and `i_fcl_allowed` and `!i_is_loading`, grant:
    - register the index;
    - clear its pending bit;
    - go to WAIT_START.
  - Otherwise stay. An externally raised `i_is_loading` blocks any grant.
- WAIT_START:
  - `i_is_loading=1` → LOADING.
  - Counter reaches `START_TIMEOUT` with no rise → pulse `o_timeout`, drop `o_req_valid`, go to IDLE. The request is not re-queued.
- LOADING: on `i_is_loading=0` → COOLDOWN if `COOLDOWN>0`, else IDLE.
- COOLDOWN: count `COOLDOWN` cycles, then IDLE.
- Output hold:
  - `o_req_valid`/`o_req_idx` are set with `o_go` and held constant through WAIT_START and LOADING.
  - They are cleared on the first cycle of COOLDOWN, or of IDLE when `COOLDOWN=0`.
- `i_fcl_allowed` falling after a grant has no effect on an in-flight load.
- Commands arriving while busy only set pending bits.

## Timing
- All outputs are registered.
- Reset values: `o_go=0`, `o_req_valid=0`, `o_req_idx=0`, `o_pending=0`, `o_busy=0`, `o_timeout=0`; state IDLE; counters 0.
- Reset value of `last_grant` is `N_CFG-1`, so the first round-robin grant is index 0.
- Command latency:
  - `i_cmd[k]` at cycle t → `o_pending[k]=1` at t+1.
  - If grantable at t+1, then at t+2: `o_go=1`, `o_req_valid=1`, `o_req_idx=k`, `o_pending[k]=0`, `o_busy=1`.
- Invariants:
  - `o_go` implies `$past(i_fcl_allowed)`, `o_req_valid`, and `o_go` low on the next cycle.
  - There are never two `o_go` pulses without an intervening IDLE cycle.
- Timeout: with `o_go` at cycle g and no `i_is_loading`, `o_timeout` pulses at g+`START_TIMEOUT`.
- Cooldown: with `i_is_loading` falling at cycle f, the next `o_go` is no earlier than f+`COOLDOWN`+2.
- `rst_n` low at any point, including mid-load, immediately clears all state and outputs. Pending requests are lost.

## Test plan
- Single command, fixed priority: `i_cmd=4'b0100` at t with allowed=1 → `o_go` at t+2 with idx=2; `o_go` low at t+3; idx held until `i_is_loading` falls.
- Simultaneous commands: `i_cmd=4'b1010`, `RR_MODE=0`, loads complete normally → grants idx 1 then idx 3; `o_pending` goes 1010→1000→0000.
- Round-robin fairness: `RR_MODE=1`, `i_cmd` re-asserted as `4'b1111` after every load → grant order 0,1,2,3,0.
- Allowed gating: pending `4'b0001` with allowed=0 for 10 cycles → no `o_go`; allowed rises at cycle a → `o_go` at a+1.
- Start timeout: grant issued, `i_is_loading` held 0 → `o_timeout` exactly 16 cycles after `o_go`; `o_req_valid` 0 the next cycle; idle again.
- Reset mid-load plus same-slot recommand: `i_cmd[1]` in the grant cycle of idx 1 → bit 1 stays pending. Then `rst_n` low during LOADING → all outputs 0 asynchronously and `o_pending=0`.
